store_access_arbiter: RTL and testbench
=======================================

Name: store_access_arbiter

Overview:
Shares the single store datapath between the three operation requesters: buy, charge/restock, and change-price. It arbitrates round-robin and validates the winning request against product range and stock limits. It then sequences one store command, emits one machine-log record, and returns a done/status pulse to the requester. It sits between the operation modules and the store/log blocks, replacing their direct, unsynchronised clock pulses to those blocks.

Parameters:
NUM_PRODUCTS, 5, valid product codes are 0..NUM_PRODUCTS-1 (max 8).
MAX_STOCK, 15, per-product stock ceiling; must fit in 4 bits.
TIMEOUT, 15, cycles to wait for store_ready or log_ready before aborting.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req  in  3  request level per requester: bit0 buy, bit1 charge, bit2 price
req_code  in  9  3-bit product code per requester; requester i uses bits [3i+2:3i]
req_arg  in  12  4-bit argument per requester: buy ignored, charge = item count, price = new price
gnt  out  3  one-hot; high from grant until done
done  out  3  one-cycle pulse to the granted requester at completion
status  out  1  result, valid when any done bit is high: 1 = ok, 0 = rejected or timeout
stock_level  in  4  current stock for store_code (combinational lookup in store)
store_valid  out  1  command strobe
store_ready  in  1  store accepts and completes command (handshake on valid&ready)
store_mode  out  2  00 buy, 01 charge, 10 price
store_code  out  3  product code
store_count  out  4  charge count (0 otherwise)
store_price  out  4  new price (0 otherwise)
log_valid  out  1  log record strobe
log_ready  in  1  logger accepts the record
log_op  out  2  01 buy, 10 charge, 11 price
log_status  out  1  same value as status
log_code  out  3  product code
log_arg  out  4  request argument

Behaviour:
- Reset (asynchronous, any state, mid-transaction included): state IDLE, rr pointer = 0, all outputs 0. No done pulse is emitted for an aborted transaction.
- States: IDLE -> LATCH -> CHECK -> STORE -> LOG -> DONE -> IDLE.
- IDLE:
  - If any req bit is set, pick the first set bit at or after the rr pointer, wrapping 2->0.
  - Assert gnt for that requester.
  - Move to LATCH.
- LATCH:
  - Capture that requester's code and argument.
  - Drive store_code so stock_level is valid next cycle.
- CHECK: evaluate the request.
  - Code >= NUM_PRODUCTS: reject.
  - Buy: reject if stock_level == 0.
  - Charge: 5-bit sum stock_level + arg; reject if sum > MAX_STOCK. Count 0 is accepted.
  - Price: always accepted if the code is in range.
  - Accept -> STORE. Reject -> status 0, skip store, go to LOG.
- STORE:
  - Hold store_valid and the fields stable until store_ready.
  - On ready: status 1 -> LOG.
  - No ready within TIMEOUT cycles: status 0, drop store_valid -> LOG.
- LOG:
  - Hold log_valid and the fields until log_ready, or until TIMEOUT cycles pass.
  - A log timeout does not change status.
  - Every granted request produces exactly one log attempt, rejected ones included.
- DONE:
  - Pulse done[i] for one cycle with status.
  - Deassert gnt next cycle.
  - rr pointer = granted index + 1, mod 3.
- Requests arriving while busy wait in their level; req deassertion mid-transaction is ignored (arguments already latched).
- Minimum latency with ready=1 on both handshakes: grant at cycle 0, done at cycle 4.
- Back-to-back: IDLE costs one cycle, so the next grant comes 1 cycle after DONE.
- Timeout counter: 4 bits wide, cleared on every state entry.

Decomposition:
- Package vm_pkg holds:
  - store_mode_t enum: BUY=00, CHARGE=01, PRICE=10.
  - log_op_t enum: BUY=01, CHARGE=10, PRICE=11.
  - arbiter state enum.
  - Constants NUM_PRODUCTS and MAX_STOCK.
- One sub-module: rr_pick3. It is combinational: req[2:0] and pointer in; one-hot grant and index out.

Test Plan:
- Reset, then buy code 2 with stock_level 3, ready=1 -> store_mode 00 code 2; log_op 01 status 1; done[0] at cycle 4.
- Charge code 1 with arg 6, stock 10 (sum 16 > 15) -> no store_valid; log_op 10, status 0, log_arg 6; done[1] status 0.
- Price request with code 6 -> rejected; log_op 11, status 0, code 6.
- All three req held continuously -> grant order 0,1,2,0; no requester starves.
- store_ready held 0 -> store_valid high for exactly 15 cycles, then log with status 0, then done.
- reset_n low while in STORE -> all outputs 0 immediately, no done pulse; next request is served normally starting from pointer 0.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine store access path.
package vm_pkg;

  localparam int NUM_PRODUCTS = 5;
  localparam int MAX_STOCK    = 15;

  typedef enum logic [1:0] {
    SM_BUY    = 2'b00,
    SM_CHARGE = 2'b01,
    SM_PRICE  = 2'b10
  } storeMode_t;

  typedef enum logic [1:0] {
    LOG_BUY    = 2'b01,
    LOG_CHARGE = 2'b10,
    LOG_PRICE  = 2'b11
  } logOp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CHECK,
    ST_STORE,
    ST_LOG,
    ST_DONE
  } arbState_t;

endpackage

// File: rtl/store_access_arbiter_rr_pick3.sv
// Combinational three-way round-robin pick: first set request at or after pointer.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] pointer,
  output logic [2:0] grant,
  output logic [1:0] index
);

  logic [1:0] slot0, slot1, slot2;

  always_comb begin
    case (pointer)
      2'd1:    begin slot0 = 2'd1; slot1 = 2'd2; slot2 = 2'd0; end
      2'd2:    begin slot0 = 2'd2; slot1 = 2'd0; slot2 = 2'd1; end
      default: begin slot0 = 2'd0; slot1 = 2'd1; slot2 = 2'd2; end
    endcase
  end

  // Lowest-priority slot is evaluated first so the pointer slot overrides it.
  always_comb begin
    grant = 3'b000;
    index = 2'd0;
    if (req[slot2]) begin
      grant        = 3'b000;
      grant[slot2] = 1'b1;
      index        = slot2;
    end
    if (req[slot1]) begin
      grant        = 3'b000;
      grant[slot1] = 1'b1;
      index        = slot1;
    end
    if (req[slot0]) begin
      grant        = 3'b000;
      grant[slot0] = 1'b1;
      index        = slot0;
    end
  end

endmodule

// File: rtl/store_access_arbiter.sv
// Round-robin arbiter that validates and sequences one store command and one
// log record per granted request, then returns a done/status pulse.
module store_access_arbiter #(
  parameter int NUM_PRODUCTS = vm_pkg::NUM_PRODUCTS,
  parameter int MAX_STOCK    = vm_pkg::MAX_STOCK,
  parameter int TIMEOUT      = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  req,
  input  logic [8:0]  req_code,
  input  logic [11:0] req_arg,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic        status,
  input  logic [3:0]  stock_level,
  output logic        store_valid,
  input  logic        store_ready,
  output logic [1:0]  store_mode,
  output logic [2:0]  store_code,
  output logic [3:0]  store_count,
  output logic [3:0]  store_price,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [1:0]  log_op,
  output logic        log_status,
  output logic [2:0]  log_code,
  output logic [3:0]  log_arg
);

  import vm_pkg::*;

  arbState_t  state, stateNext;
  logic [1:0] rrPtr;
  logic [2:0] gntReg;
  logic [1:0] idxReg;
  logic [2:0] codeReg;
  logic [3:0] argReg;
  logic       statusReg, statusNext;
  logic [3:0] toCnt;
  logic [2:0] pickGrant;
  logic [1:0] pickIndex;
  logic       codeOk, accept, timeoutHit;
  logic [4:0] chargeSum;
  storeMode_t modeSel;
  logOp_t     opSel;

  rr_pick3 uPick (
    .req     (req),
    .pointer (rrPtr),
    .grant   (pickGrant),
    .index   (pickIndex)
  );

  assign codeOk     = int'(codeReg) < NUM_PRODUCTS;
  assign chargeSum  = {1'b0, stock_level} + {1'b0, argReg};
  assign timeoutHit = (toCnt == 4'(TIMEOUT - 1));

  always_comb begin
    case (idxReg)
      2'd0:    accept = codeOk && (stock_level != 4'd0);
      2'd1:    accept = codeOk && (int'(chargeSum) <= MAX_STOCK);
      default: accept = codeOk;
    endcase
  end

  always_comb begin
    case (idxReg)
      2'd1:    begin modeSel = SM_CHARGE; opSel = LOG_CHARGE; end
      2'd2:    begin modeSel = SM_PRICE;  opSel = LOG_PRICE;  end
      default: begin modeSel = SM_BUY;    opSel = LOG_BUY;    end
    endcase
  end

  // Control state; the counter restarts whenever the state changes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rrPtr     <= 2'd0;
      gntReg    <= 3'b000;
      idxReg    <= 2'd0;
      statusReg <= 1'b0;
      toCnt     <= 4'd0;
    end else begin
      state     <= stateNext;
      statusReg <= statusNext;
      toCnt     <= (stateNext != state) ? 4'd0 : toCnt + 4'd1;
      if (state == ST_IDLE && |req) begin
        gntReg <= pickGrant;
        idxReg <= pickIndex;
      end
      if (state == ST_DONE)
        rrPtr <= (idxReg == 2'd2) ? 2'd0 : idxReg + 2'd1;
    end
  end

  // Request fields are captured with the grant; outputs gate them by state.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && |req) begin
      case (pickIndex)
        2'd1:    begin codeReg <= req_code[5:3]; argReg <= req_arg[7:4];  end
        2'd2:    begin codeReg <= req_code[8:6]; argReg <= req_arg[11:8]; end
        default: begin codeReg <= req_code[2:0]; argReg <= req_arg[3:0];  end
      endcase
    end
  end

  always_comb begin
    stateNext   = state;
    statusNext  = statusReg;
    gnt         = (state == ST_IDLE) ? 3'b000 : gntReg;
    done        = 3'b000;
    status      = 1'b0;
    store_valid = 1'b0;
    store_mode  = 2'b00;
    store_code  = 3'd0;
    store_count = 4'd0;
    store_price = 4'd0;
    log_valid   = 1'b0;
    log_op      = 2'b00;
    log_status  = 1'b0;
    log_code    = 3'd0;
    log_arg     = 4'd0;
    case (state)
      ST_IDLE: begin
        if (|req) stateNext = ST_LATCH;
      end
      ST_LATCH: begin
        store_code = codeReg;
        stateNext  = ST_CHECK;
      end
      ST_CHECK: begin
        store_code = codeReg;
        if (accept) begin
          stateNext = ST_STORE;
        end else begin
          statusNext = 1'b0;
          stateNext  = ST_LOG;
        end
      end
      ST_STORE: begin
        store_valid = 1'b1;
        store_mode  = modeSel;
        store_code  = codeReg;
        store_count = (idxReg == 2'd1) ? argReg : 4'd0;
        store_price = (idxReg == 2'd2) ? argReg : 4'd0;
        if (store_ready) begin
          statusNext = 1'b1;
          stateNext  = ST_LOG;
        end else if (timeoutHit) begin
          statusNext = 1'b0;
          stateNext  = ST_LOG;
        end
      end
      ST_LOG: begin
        log_valid  = 1'b1;
        log_op     = opSel;
        log_status = statusReg;
        log_code   = codeReg;
        log_arg    = argReg;
        if (log_ready || timeoutHit) stateNext = ST_DONE;
      end
      ST_DONE: begin
        done      = gntReg;
        status    = statusReg;
        stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_access_arbiter.sv
// Self-checking bench for store_access_arbiter with a transaction-level model.
module tb_store_access_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [8:0]  req_code = 9'd0;
  logic [11:0] req_arg = 12'd0;
  logic [2:0]  gnt, done;
  logic        status;
  logic [3:0]  stock_level;
  logic        store_valid;
  logic        store_ready = 1'b1;
  logic [1:0]  store_mode;
  logic [2:0]  store_code;
  logic [3:0]  store_count, store_price;
  logic        log_valid;
  logic        log_ready = 1'b1;
  logic [1:0]  log_op;
  logic        log_status;
  logic [2:0]  log_code;
  logic [3:0]  log_arg;

  logic [3:0]  stockMem [8];
  logic [31:0] allOut;
  int          nChecks = 0;
  int          nPass = 0;
  int          modelPtr = 0;

  store_access_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .req_code    (req_code),
    .req_arg     (req_arg),
    .gnt         (gnt),
    .done        (done),
    .status      (status),
    .stock_level (stock_level),
    .store_valid (store_valid),
    .store_ready (store_ready),
    .store_mode  (store_mode),
    .store_code  (store_code),
    .store_count (store_count),
    .store_price (store_price),
    .log_valid   (log_valid),
    .log_ready   (log_ready),
    .log_op      (log_op),
    .log_status  (log_status),
    .log_code    (log_code),
    .log_arg     (log_arg)
  );

  always #5 clock = ~clock;

  always_comb stock_level = stockMem[store_code];

  assign allOut = {gnt, done, status, store_valid, store_mode, store_code, store_count,
                   store_price, log_valid, log_op, log_status, log_code, log_arg};

  typedef struct {
    bit         timedOut;
    logic [2:0] gnt;
    int         idleWait;
    bit         gntGlitch;
    int         storeCycles;
    logic [1:0] sMode;
    logic [2:0] sCode;
    logic [3:0] sCount;
    logic [3:0] sPrice;
    bit         storeUnstable;
    int         logCycles;
    logic [1:0] lOp;
    logic       lStatus;
    logic [2:0] lCode;
    logic [3:0] lArg;
    logic [2:0] done;
    logic       status;
    int         doneCycle;
    logic [2:0] gntAfter;
  } obs_t;

  task automatic set_req(input int idx, input int code, input int arg);
    req[idx]           = 1'b1;
    req_code[3*idx +: 3] = 3'(code);
    req_arg[4*idx +: 4]  = 4'(arg);
  endtask

  // Records one transaction from grant to the cycle after done; cycle 0 is the grant cycle.
  task automatic observe(output obs_t o);
    int c;
    o = '{default: 0};
    c = 0;
    while (gnt === 3'b000 && c < 60) begin
      @(negedge clock);
      c++;
    end
    o.idleWait = c;
    if (gnt === 3'b000) begin
      o.timedOut = 1'b1;
      return;
    end
    o.gnt = gnt;
    c = 0;
    while (c < 80) begin
      if (gnt !== o.gnt) o.gntGlitch = 1'b1;
      if (store_valid === 1'b1) begin
        if (o.storeCycles == 0) begin
          o.sMode = store_mode; o.sCode = store_code;
          o.sCount = store_count; o.sPrice = store_price;
        end else if ({o.sMode, o.sCode, o.sCount, o.sPrice} !==
                     {store_mode, store_code, store_count, store_price}) begin
          o.storeUnstable = 1'b1;
        end
        o.storeCycles++;
      end
      if (log_valid === 1'b1) begin
        if (o.logCycles == 0) begin
          o.lOp = log_op; o.lStatus = log_status; o.lCode = log_code; o.lArg = log_arg;
        end
        o.logCycles++;
      end
      if (done !== 3'b000) begin
        o.done = done;
        o.status = status;
        o.doneCycle = c;
        break;
      end
      @(negedge clock);
      c++;
    end
    if (o.done === 3'b000) begin
      o.timedOut = 1'b1;
      return;
    end
    @(negedge clock);
    o.gntAfter = gnt;
  endtask

  // Outcome of one request from the rules alone: accept, ok status and cycle counts.
  function automatic void model(input int idx, input int code, input int arg, input int stock,
                                input bit sRdy, input bit lRdy, output bit acc, output bit ok,
                                output int sCyc, output int lCyc, output int doneCyc);
    bit inRange;
    inRange = code < 5;
    case (idx)
      0:       acc = inRange && stock > 0;
      1:       acc = inRange && (stock + arg) <= 15;
      default: acc = inRange;
    endcase
    sCyc = acc ? (sRdy ? 1 : 15) : 0;
    ok = acc && sRdy;
    lCyc = lRdy ? 1 : 15;
    doneCyc = 2 + sCyc + lCyc;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    nChecks++; if (allOut !== 32'd0) $display("FAIL reset_outputs: got %h want 0", allOut); else nPass++;
    reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
    nChecks++; if (allOut !== 32'd0) $display("FAIL idle_outputs: got %h want 0", allOut); else nPass++;
    modelPtr = 0;
  endtask

  task automatic test_buy();
    obs_t o;
    stockMem[2] = 4'd3;
    store_ready = 1'b1; log_ready = 1'b1;
    set_req(0, 2, 9);
    observe(o);
    req = 3'b000;
    nChecks++; if (o.timedOut) $display("FAIL buy_timeout: got 1 want 0"); else nPass++;
    nChecks++; if (o.gnt !== 3'b001) $display("FAIL buy_gnt: got %b want 001", o.gnt); else nPass++;
    nChecks++; if (o.storeCycles != 1) $display("FAIL buy_store_cycles: got %0d want 1", o.storeCycles); else nPass++;
    nChecks++; if ({o.sMode, o.sCode, o.sCount, o.sPrice} !== {2'b00, 3'd2, 4'd0, 4'd0})
      $display("FAIL buy_store_fields: got %b %0d %0d %0d want 00 2 0 0", o.sMode, o.sCode, o.sCount, o.sPrice); else nPass++;
    nChecks++; if ({o.lOp, o.lStatus, o.lCode} !== {2'b01, 1'b1, 3'd2})
      $display("FAIL buy_log: got op %b st %b code %0d want 01 1 2", o.lOp, o.lStatus, o.lCode); else nPass++;
    nChecks++; if (o.done !== 3'b001 || o.status !== 1'b1)
      $display("FAIL buy_done: got %b/%b want 001/1", o.done, o.status); else nPass++;
    nChecks++; if (o.doneCycle != 4) $display("FAIL buy_latency: got %0d want 4", o.doneCycle); else nPass++;
    nChecks++; if (o.gntAfter !== 3'b000) $display("FAIL buy_gnt_release: got %b want 000", o.gntAfter); else nPass++;
    modelPtr = 1;
  endtask

  task automatic test_charge_reject();
    obs_t o;
    stockMem[1] = 4'd10;
    set_req(1, 1, 6);
    observe(o);
    req = 3'b000;
    nChecks++; if (o.timedOut) $display("FAIL charge_timeout: got 1 want 0"); else nPass++;
    nChecks++; if (o.storeCycles != 0) $display("FAIL charge_no_store: got %0d want 0", o.storeCycles); else nPass++;
    nChecks++; if ({o.lOp, o.lStatus, o.lArg} !== {2'b10, 1'b0, 4'd6})
      $display("FAIL charge_log: got op %b st %b arg %0d want 10 0 6", o.lOp, o.lStatus, o.lArg); else nPass++;
    nChecks++; if (o.done !== 3'b010 || o.status !== 1'b0)
      $display("FAIL charge_done: got %b/%b want 010/0", o.done, o.status); else nPass++;
    nChecks++; if (o.doneCycle != 3) $display("FAIL charge_latency: got %0d want 3", o.doneCycle); else nPass++;
    modelPtr = 2;
  endtask

  task automatic test_price_reject();
    obs_t o;
    stockMem[6] = 4'd5;
    set_req(2, 6, 7);
    observe(o);
    req = 3'b000;
    nChecks++; if (o.timedOut) $display("FAIL price_timeout: got 1 want 0"); else nPass++;
    nChecks++; if (o.storeCycles != 0) $display("FAIL price_no_store: got %0d want 0", o.storeCycles); else nPass++;
    nChecks++; if ({o.lOp, o.lStatus, o.lCode} !== {2'b11, 1'b0, 3'd6})
      $display("FAIL price_log: got op %b st %b code %0d want 11 0 6", o.lOp, o.lStatus, o.lCode); else nPass++;
    nChecks++; if (o.done !== 3'b100 || o.status !== 1'b0)
      $display("FAIL price_done: got %b/%b want 100/0", o.done, o.status); else nPass++;
    modelPtr = 0;
  endtask

  task automatic test_round_robin();
    obs_t o;
    int   w;
    stockMem[0] = 4'd3;
    set_req(0, 0, 0);
    set_req(1, 0, 1);
    set_req(2, 0, 4);
    for (int n = 0; n < 4; n++) begin
      w = modelPtr;
      observe(o);
      nChecks++; if (o.gnt !== 3'(1 << w)) $display("FAIL rr_gnt%0d: got %b want %b", n, o.gnt, 3'(1 << w)); else nPass++;
      nChecks++; if (o.done !== 3'(1 << w) || o.status !== 1'b1)
        $display("FAIL rr_done%0d: got %b/%b want %b/1", n, o.done, o.status, 3'(1 << w)); else nPass++;
      if (n > 0) begin
        nChecks++; if (o.idleWait != 1) $display("FAIL rr_back_to_back%0d: got %0d want 1", n, o.idleWait); else nPass++;
      end
      modelPtr = (w + 1) % 3;
    end
    req = 3'b000;
  endtask

  task automatic test_boundaries();
    int   tIdx[7]   = '{1, 1, 0, 0, 2, 2, 0};
    int   tCode[7]  = '{1, 4, 3, 4, 5, 4, 7};
    int   tArg[7]   = '{5, 0, 0, 9, 7, 7, 2};
    int   tStock[7] = '{10, 15, 0, 1, 4, 4, 5};
    int   tOk[7]    = '{1, 1, 0, 1, 0, 1, 0};
    obs_t o;
    for (int n = 0; n < 7; n++) begin
      stockMem[tCode[n]] = 4'(tStock[n]);
      set_req(tIdx[n], tCode[n], tArg[n]);
      observe(o);
      req = 3'b000;
      nChecks++; if (o.status !== 1'(tOk[n]) || o.done !== 3'(1 << tIdx[n]))
        $display("FAIL bound%0d_status: got %b/%b want %b/%b", n, o.done, o.status, 3'(1 << tIdx[n]), 1'(tOk[n])); else nPass++;
      nChecks++; if (o.storeCycles != tOk[n])
        $display("FAIL bound%0d_store: got %0d want %0d", n, o.storeCycles, tOk[n]); else nPass++;
      modelPtr = (tIdx[n] + 1) % 3;
    end
  endtask

  task automatic test_store_timeout();
    obs_t o;
    stockMem[3] = 4'd5;
    store_ready = 1'b0;
    set_req(0, 3, 0);
    observe(o);
    req = 3'b000;
    store_ready = 1'b1;
    nChecks++; if (o.storeCycles != 15) $display("FAIL store_to_cycles: got %0d want 15", o.storeCycles); else nPass++;
    nChecks++; if (o.logCycles != 1 || o.lStatus !== 1'b0)
      $display("FAIL store_to_log: got %0d/%b want 1/0", o.logCycles, o.lStatus); else nPass++;
    nChecks++; if (o.done !== 3'b001 || o.status !== 1'b0)
      $display("FAIL store_to_done: got %b/%b want 001/0", o.done, o.status); else nPass++;
    nChecks++; if (o.doneCycle != 18) $display("FAIL store_to_latency: got %0d want 18", o.doneCycle); else nPass++;
    modelPtr = 1;
  endtask

  task automatic test_log_timeout();
    obs_t o;
    log_ready = 1'b0;
    set_req(2, 1, 9);
    observe(o);
    req = 3'b000;
    log_ready = 1'b1;
    nChecks++; if (o.logCycles != 15) $display("FAIL log_to_cycles: got %0d want 15", o.logCycles); else nPass++;
    nChecks++; if (o.status !== 1'b1 || o.lStatus !== 1'b1)
      $display("FAIL log_to_status: got %b/%b want 1/1", o.status, o.lStatus); else nPass++;
    nChecks++; if (o.sPrice !== 4'd9 || o.sMode !== 2'b10)
      $display("FAIL log_to_store: got price %0d mode %b want 9 10", o.sPrice, o.sMode); else nPass++;
    modelPtr = 0;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   c;
    bit   sawDone;
    stockMem[1] = 4'd3;
    set_req(0, 1, 0);
    observe(o);
    req = 3'b000;
    nChecks++; if (o.status !== 1'b1) $display("FAIL rmid_setup: got %b want 1", o.status); else nPass++;
    store_ready = 1'b0;
    set_req(1, 1, 2);
    c = 0;
    while (store_valid !== 1'b1 && c < 20) begin
      @(negedge clock);
      c++;
    end
    nChecks++; if (store_valid !== 1'b1) $display("FAIL rmid_store_wait: got %b want 1", store_valid); else nPass++;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    nChecks++; if (allOut !== 32'd0) $display("FAIL rmid_outputs: got %h want 0", allOut); else nPass++;
    sawDone = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done !== 3'b000) sawDone = 1'b1;
    end
    nChecks++; if (sawDone) $display("FAIL rmid_no_done: got 1 want 0"); else nPass++;
    reset_n = 1'b1;
    store_ready = 1'b1;
    modelPtr = 0;
    stockMem[0] = 4'd2;
    set_req(0, 0, 0);
    set_req(1, 0, 1);
    set_req(2, 0, 3);
    observe(o);
    req = 3'b000;
    nChecks++; if (o.gnt !== 3'b001 || o.done !== 3'b001 || o.status !== 1'b1)
      $display("FAIL rmid_restart: got %b %b/%b want 001 001/1", o.gnt, o.done, o.status); else nPass++;
    modelPtr = 1;
  endtask

  task automatic test_random();
    obs_t o;
    int   mask, w, code[3], arg[3];
    int   sCyc, lCyc, dCyc;
    bit   acc, ok, sRdy, lRdy;
    for (int n = 0; n < 40; n++) begin
      for (int p = 0; p < 8; p++) stockMem[p] = 4'($urandom_range(0, 15));
      mask = $urandom_range(1, 7);
      sRdy = ($urandom_range(0, 7) != 0);
      lRdy = ($urandom_range(0, 7) != 0);
      store_ready = sRdy;
      log_ready = lRdy;
      for (int i = 0; i < 3; i++) begin
        code[i] = $urandom_range(0, 7);
        arg[i] = $urandom_range(0, 15);
        if (mask[i]) set_req(i, code[i], arg[i]);
      end
      w = -1;
      for (int k = 2; k >= 0; k--) if (mask[(modelPtr + k) % 3]) w = (modelPtr + k) % 3;
      model(w, code[w], arg[w], int'(stockMem[code[w]]), sRdy, lRdy, acc, ok, sCyc, lCyc, dCyc);
      observe(o);
      req = 3'b000;
      nChecks++; if (o.timedOut || o.gntGlitch)
        $display("FAIL rnd%0d_flow: got to %b glitch %b want 0 0", n, o.timedOut, o.gntGlitch); else nPass++;
      nChecks++; if (o.gnt !== 3'(1 << w) || o.done !== 3'(1 << w))
        $display("FAIL rnd%0d_gnt: got %b/%b want %b", n, o.gnt, o.done, 3'(1 << w)); else nPass++;
      nChecks++; if (o.status !== ok || o.lStatus !== ok)
        $display("FAIL rnd%0d_status: got %b/%b want %b", n, o.status, o.lStatus, ok); else nPass++;
      nChecks++; if (o.storeCycles != sCyc || o.logCycles != lCyc || o.doneCycle != dCyc)
        $display("FAIL rnd%0d_timing: got %0d %0d %0d want %0d %0d %0d", n, o.storeCycles, o.logCycles,
                 o.doneCycle, sCyc, lCyc, dCyc); else nPass++;
      nChecks++; if ({o.lOp, o.lCode, o.lArg} !== {2'(w + 1), 3'(code[w]), 4'(arg[w])})
        $display("FAIL rnd%0d_log: got %b %0d %0d want %b %0d %0d", n, o.lOp, o.lCode, o.lArg,
                 2'(w + 1), code[w], arg[w]); else nPass++;
      if (acc) begin
        nChecks++; if ({o.sMode, o.sCode, o.sCount, o.sPrice} !==
                       {2'(w), 3'(code[w]), (w == 1) ? 4'(arg[w]) : 4'd0, (w == 2) ? 4'(arg[w]) : 4'd0}
                       || o.storeUnstable)
          $display("FAIL rnd%0d_store: got %b %0d %0d %0d unstable %b", n, o.sMode, o.sCode, o.sCount,
                   o.sPrice, o.storeUnstable); else nPass++;
      end
      modelPtr = (w + 1) % 3;
    end
    store_ready = 1'b1;
    log_ready = 1'b1;
  endtask

  initial begin
    for (int p = 0; p < 8; p++) stockMem[p] = 4'd0;
    test_reset();
    test_buy();
    test_charge_reject();
    test_price_reject();
    test_round_robin();
    test_boundaries();
    test_store_timeout();
    test_log_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
